// File: rtl/lfsr_seq_master.sv
// Wishbone master that seeds the LFSR peripheral, releases it, then reads back
// N single-bit samples and packs them MSB-first into o_word.
module lfsr_seq_master #(
  parameter int MAX_BITS = 32,
  parameter int TIMEOUT  = 15
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_skip_seed,
  input  logic [31:0]         i_seed,
  input  logic [5:0]          i_nbits,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [MAX_BITS-1:0] o_word,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [2:0]          o_wb_addr,
  output logic [7:0]          o_wb_data,
  input  logic                i_wb_stall,
  input  logic                i_wb_ack,
  input  logic                i_wb_data
);

  localparam int              WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [5:0]      NBITS_MAX = 6'(MAX_BITS);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SEED, CTRL_LOAD, CTRL_RUN, READ, DONE
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     seed_q;
  logic [1:0]      byte_idx;
  logic [5:0]      remain;
  logic [WD_W-1:0] wdog;
  logic            pend;
  logic            err_q;

  logic start_ok, accept, ack_ok, timeout, launch;

  assign start_ok = (state == IDLE) && i_start;
  assign accept   = o_wb_stb && !i_wb_stall;
  assign ack_ok   = pend && i_wb_ack;
  // An ack arriving in the last watchdog cycle still completes the transfer.
  assign timeout  = pend && !i_wb_ack && (wdog == WD_LAST);
  assign launch   = start_ok || (ack_ok && (state_nxt != DONE));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (i_start) state_nxt = i_skip_seed ? READ : SEED;
      SEED: begin
        if (timeout)                         state_nxt = DONE;
        else if (ack_ok && byte_idx == 2'd3) state_nxt = CTRL_LOAD;
      end
      CTRL_LOAD: begin
        if (timeout)     state_nxt = DONE;
        else if (ack_ok) state_nxt = CTRL_RUN;
      end
      CTRL_RUN: begin
        if (timeout)     state_nxt = DONE;
        else if (ack_ok) state_nxt = READ;
      end
      READ: begin
        if (timeout)                       state_nxt = DONE;
        else if (ack_ok && remain == 6'd1) state_nxt = DONE;
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wb_stb <= 1'b0;
      pend     <= 1'b0;
      wdog     <= '0;
      byte_idx <= 2'd0;
      remain   <= 6'd0;
      err_q    <= 1'b0;
      o_word   <= '0;
    end else begin
      if (launch)      o_wb_stb <= 1'b1;
      else if (accept) o_wb_stb <= 1'b0;

      if (accept)                 pend <= 1'b1;
      else if (ack_ok || timeout) pend <= 1'b0;

      if (accept)    wdog <= '0;
      else if (pend) wdog <= wdog + 1'b1;

      if (start_ok)                     byte_idx <= 2'd0;
      else if (state == SEED && ack_ok) byte_idx <= byte_idx + 2'd1;

      if (start_ok) begin
        if (i_nbits == 6'd0 || i_nbits > NBITS_MAX) remain <= NBITS_MAX;
        else                                        remain <= i_nbits;
      end else if (state == READ && ack_ok) begin
        remain <= remain - 6'd1;
      end

      if (start_ok)     err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;

      if (start_ok)                     o_word <= '0;
      else if (state == READ && ack_ok) o_word <= {o_word[MAX_BITS-2:0], i_wb_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (start_ok) seed_q <= i_seed;
  end

  assign o_busy   = (state != IDLE) && (state != DONE);
  assign o_done   = (state == DONE);
  assign o_err    = o_done && err_q;
  assign o_wb_cyc = o_busy;

  // Address/data follow the state, so they stay put for as long as the slave stalls.
  always_comb begin
    o_wb_we   = 1'b0;
    o_wb_addr = 3'd0;
    o_wb_data = 8'd0;
    case (state)
      SEED: begin
        o_wb_we   = 1'b1;
        o_wb_addr = {1'b0, byte_idx};
        o_wb_data = seed_q[{byte_idx, 3'b000} +: 8];
      end
      CTRL_LOAD: begin
        o_wb_we   = 1'b1;
        o_wb_addr = 3'd4;
        o_wb_data = 8'h02;
      end
      CTRL_RUN: begin
        o_wb_we   = 1'b1;
        o_wb_addr = 3'd4;
        o_wb_data = 8'h00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lfsr_seq_master.sv
// Bench for lfsr_seq_master: reactive Wishbone slave, transaction-level model
// of the expected bus traffic and result word, per-cycle compare process.
module tb_lfsr_seq_master;
  localparam int MAX_BITS = 32;
  localparam int TIMEOUT  = 15;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_skip_seed = 1'b0;
  logic [31:0] i_seed = 32'd0;
  logic [5:0]  i_nbits = 6'd0;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_word;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [2:0]  o_wb_addr;
  logic [7:0]  o_wb_data;
  logic        i_wb_stall = 1'b0;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_data = 1'b0;

  lfsr_seq_master #(.MAX_BITS(MAX_BITS), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_skip_seed(i_skip_seed),
    .i_seed(i_seed), .i_nbits(i_nbits), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_word(o_word), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  // Model: expected {we, addr, data} transfers, final word, error and done cycle.
  logic [11:0] exp_q[$];
  logic [31:0] exp_word = 32'd0;
  logic [31:0] mdl_word = 32'd0;
  logic        exp_err = 1'b0;
  int          exp_done_cyc = -1;
  int          exp_left = 0;

  // Slave configuration and state.
  logic       sl_bits[$];
  int         sl_reads = 0;
  int         sl_drop_read = 0;
  int         sl_stall_n = 3;
  int         sl_stall_left = 0;
  logic [2:0] sl_stall_addr = 3'd2;
  logic       sl_stall_armed = 1'b0;
  logic       sl_stray_ack = 1'b0;
  logic       sl_last_stb = 1'b0;
  logic       sl_last_stall = 1'b0;
  logic       sl_last_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Slave: acks one cycle after acceptance, optionally stalls or never acks a read.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (i_reset) begin
        sl_last_stb = 1'b0; sl_last_stall = 1'b0; sl_last_we = 1'b0; sl_stall_left = 0;
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = 1'b0;
      end else begin
        i_wb_ack  = 1'b0;
        i_wb_data = 1'b0;
        if (sl_last_stb && !sl_last_stall) begin
          if (!sl_last_we) begin
            sl_reads++;
            if (sl_reads != sl_drop_read) begin
              i_wb_ack  = 1'b1;
              i_wb_data = (sl_bits.size() > 0) ? sl_bits.pop_front() : 1'b0;
            end
          end else begin
            i_wb_ack = 1'b1;
          end
        end
        if (sl_stray_ack) begin
          i_wb_ack = 1'b1;
          sl_stray_ack = 1'b0;
        end
        i_wb_stall = 1'b0;
        if (o_wb_stb && o_wb_we && o_wb_addr == sl_stall_addr && sl_stall_armed) begin
          sl_stall_left  = sl_stall_n;
          sl_stall_armed = 1'b0;
        end
        if (o_wb_stb && sl_stall_left > 0) begin
          i_wb_stall = 1'b1;
          sl_stall_left--;
        end
        sl_last_stb = o_wb_stb; sl_last_stall = i_wb_stall; sl_last_we = o_wb_we;
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  initial begin : compare
    logic        p_stb, p_stall, p_done;
    logic [11:0] p_bus, cur;
    p_stb = 1'b0; p_stall = 1'b0; p_done = 1'b0; p_bus = '0;
    forever begin
      @(negedge i_clk);
      cur = {o_wb_we, o_wb_addr, o_wb_data};
      if (i_reset) begin
        p_stb = 1'b0; p_stall = 1'b0; p_done = 1'b0;
      end else begin
        if (!o_wb_we) check("wdata_zero_on_read", 32'(o_wb_data), 32'd0);
        if (!o_done)  check("err_only_with_done", 32'(o_err), 32'd0);
        if (p_stb && p_stall) begin
          check("stb_held", 32'(o_wb_stb), 32'd1);
          check("bus_held", 32'(cur), 32'(p_bus));
        end
        if (o_wb_stb) begin
          check("cyc_with_stb", 32'(o_wb_cyc), 32'd1);
          check("busy_with_stb", 32'(o_busy), 32'd1);
          check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            check("bus_xfer", 32'(cur), 32'(exp_q[0]));
            if (!i_wb_stall) void'(exp_q.pop_front());
          end
        end
        if (p_done) begin
          check("done_one_cycle", 32'(o_done), 32'd0);
          check("idle_after_done", 32'(o_busy), 32'd0);
        end
        if (!o_busy) begin
          check("cyc_idle", 32'(o_wb_cyc), 32'd0);
          check("stb_idle", 32'(o_wb_stb), 32'd0);
        end
        if (!o_busy && !o_done) check("word_hold", o_word, mdl_word);
        if (o_done) begin
          check("done_cycle", 32'(cyc_cnt), 32'(exp_done_cyc));
          check("word", o_word, exp_word);
          check("err", 32'(o_err), 32'(exp_err));
          check("xfers_left", 32'(exp_q.size()), 32'(exp_left));
          mdl_word = exp_word;
        end
        p_stb = o_wb_stb; p_stall = i_wb_stall; p_bus = cur; p_done = o_done;
      end
    end
  end

  // pat[i] is the i-th bit the slave returns in time.
  task automatic start_req(input logic [31:0] seed, input logic [5:0] nb, input logic skip,
                           input logic [31:0] pat, input logic stall_en, input int drop,
                           input int extra, input logic [31:0] pin_word, input int pin_done);
    int          n, delivered, k, start;
    logic [31:0] w;
    @(posedge i_clk);
    #2;
    n = (nb == 6'd0 || nb > 6'd32) ? 32 : int'(nb);
    exp_q.delete();
    sl_bits.delete();
    if (!skip) begin
      for (int b = 0; b < 4; b++) exp_q.push_back({1'b1, 3'(b), seed[8*b +: 8]});
      exp_q.push_back({1'b1, 3'd4, 8'h02});
      exp_q.push_back({1'b1, 3'd4, 8'h00});
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, 3'd0, 8'h00});
      sl_bits.push_back(pat[i]);
    end
    delivered = (drop != 0) ? drop - 1 : n;
    w = 32'd0;
    for (int i = 0; i < delivered; i++) w = (w << 1) | {31'd0, pat[i]};
    exp_word = w;
    exp_err  = (drop != 0);
    exp_left = (drop != 0) ? n - drop : 0;
    start    = cyc_cnt;
    k        = (skip ? 0 : 6) + delivered;
    exp_done_cyc = (drop != 0) ? start + 2 * k + TIMEOUT + 2 + extra
                               : start + 2 * k + 1 + extra;
    if (pin_done > 0) check("pin_latency", 32'(exp_done_cyc - start), 32'(pin_done));
    check("pin_word", exp_word, pin_word);
    sl_reads = 0; sl_drop_read = drop; sl_stall_armed = stall_en; sl_stall_left = 0;
    i_seed = seed; i_nbits = nb; i_skip_seed = skip; i_start = 1'b1;
    @(posedge i_clk);
    #2;
    i_start = 1'b0; i_seed = ~seed; i_nbits = 6'd3; i_skip_seed = ~skip;
    @(negedge i_clk);
    check("busy_cycle1", 32'(o_busy), 32'd1);
    check("stb_cycle1", 32'(o_wb_stb), 32'd1);
  endtask

  task automatic wait_done(input logic poke_done);
    int k = 0;
    while (!o_done && k < 300) begin
      @(negedge i_clk);
      k++;
    end
    check("done_seen", 32'(o_done), 32'd1);
    if (poke_done) begin
      i_start = 1'b1; i_seed = 32'h0F0F0F0F;
      @(posedge i_clk);
      #2;
      i_start = 1'b0;
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic run_req(input logic [31:0] seed, input logic [5:0] nb, input logic skip,
                         input logic [31:0] pat, input logic stall_en, input int drop,
                         input int extra, input logic [31:0] pin_word, input int pin_done,
                         input logic poke);
    start_req(seed, nb, skip, pat, stall_en, drop, extra, pin_word, pin_done);
    if (poke) begin
      repeat (4) @(posedge i_clk);
      #2;
      i_start = 1'b1;
      @(posedge i_clk);
      #2;
      i_start = 1'b0;
    end
    wait_done(poke);
  endtask

  initial begin
    int k;
    repeat (2) @(posedge i_clk);
    #2;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_word", o_word, 32'd0);
    check("rst_bus", 32'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data}), 32'd0);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    // Seeded run, bits 1,0,1,1,0,0,1,0; starts during busy and DONE are ignored.
    run_req(32'h00000001, 6'd8, 1'b0, 32'h0000004D, 1'b0, 0, 0, 32'h000000B2, 29, 1'b1);

    // Stray ack while idle.
    sl_stray_ack = 1'b1;
    repeat (3) @(negedge i_clk);
    check("stray_ack_busy", 32'(o_busy), 32'd0);

    // Skip seed, nbits=0 means 32, all ones.
    run_req(32'hDEADBEEF, 6'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 0, 0, 32'hFFFFFFFF, 65, 1'b0);
    // Three stall cycles on the addr 2 write.
    run_req(32'h00000001, 6'd8, 1'b0, 32'h0000004D, 1'b1, 0, 3, 32'h000000B2, 32, 1'b0);
    // Third read never acked.
    run_req(32'hA5C31E77, 6'd8, 1'b0, 32'h00000001, 1'b0, 3, 0, 32'h00000002, 33, 1'b0);
    // nbits above MAX_BITS clamps to 32.
    run_req(32'h00000000, 6'd45, 1'b1, 32'h12345678, 1'b0, 0, 0, 32'h1E6A2C48, 65, 1'b0);
    run_req(32'h87654321, 6'd5, 1'b0, 32'h00000016, 1'b0, 0, 0, 32'h0000000D, 23, 1'b1);

    // Reset during READ.
    start_req(32'hCAFEF00D, 6'd16, 1'b0, 32'h0000A5A5, 1'b0, 0, 0, 32'h0000A5A5, 45);
    k = 0;
    while (!(o_wb_stb && !o_wb_we) && k < 100) begin
      @(negedge i_clk);
      k++;
    end
    check("reached_read", 32'(o_wb_stb && !o_wb_we), 32'd1);
    repeat (3) @(negedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_done_err", 32'({o_done, o_err}), 32'd0);
    check("arst_word", o_word, 32'd0);
    check("arst_bus", 32'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data}), 32'd0);
    exp_q.delete();
    mdl_word = 32'd0;
    exp_done_cyc = -1;
    @(posedge i_clk);
    @(negedge i_clk);
    #2;
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    run_req(32'h00000001, 6'd8, 1'b0, 32'h0000004D, 1'b0, 0, 0, 32'h000000B2, 29, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_limit: got no end, want end before 200000");
    $fatal(1, "simulation time limit");
  end

endmodule
